// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_OPCODE  = 2'd0,
        S_OPERAND = 2'd1,
        S_EXEC    = 2'd2
    } fetch_state_t;

    localparam logic [1:0] INT_NONE  = 2'd0;
    localparam logic [1:0] INT_IRQ   = 2'd1;
    localparam logic [1:0] INT_NMI   = 2'd2;
    localparam logic [1:0] INT_RESET = 2'd3;

    localparam logic [7:0] OP_BRK = 8'h00;

endpackage

// File: rtl/fetch_unit_int_ctl.sv
// Interrupt control: NMI edge detection, pending flags for reset/NMI, and
// the priority encoder that picks which source a forced BRK reports.
module int_ctl
    import fetch_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       nmi_n,
    input  logic       irq_n,
    input  logic       i_flag,
    input  logic       capture,
    output logic       pending,
    output logic [1:0] src
);

    logic nmi_q;
    logic nmi_latch;
    logic reset_pending;
    logic nmi_edge;
    logic irq_pend;

    assign nmi_edge = nmi_q && !nmi_n;
    assign irq_pend = !irq_n && !i_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            nmi_q         <= 1'b1;
            nmi_latch     <= 1'b0;
            reset_pending <= 1'b1;
        end else begin
            nmi_q <= nmi_n;
            // A new edge in the capture cycle must win over the clear.
            if (nmi_edge) begin
                nmi_latch <= 1'b1;
            end else if (capture && src == INT_NMI) begin
                nmi_latch <= 1'b0;
            end
            if (capture && src == INT_RESET) begin
                reset_pending <= 1'b0;
            end
        end
    end

    always_comb begin
        src = INT_NONE;
        if (reset_pending) begin
            src = INT_RESET;
        end else if (nmi_latch) begin
            src = INT_NMI;
        end else if (irq_pend) begin
            src = INT_IRQ;
        end
    end

    assign pending = (src != INT_NONE);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches opcode and first operand,
// injects forced BRK for reset/NMI/IRQ and holds the instruction for execution.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] PC_INIT = 16'h0000
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         rdy,
    input  logic [7:0]   data_i,
    output logic [15:0]  addr_o,
    input  logic         fetch_req,
    input  logic         single_byte,
    input  logic         pc_inc,
    input  logic         pc_load,
    input  logic [15:0]  pc_in,
    input  logic         nmi_n,
    input  logic         irq_n,
    input  logic         i_flag,
    output logic [7:0]   opcode,
    output logic [7:0]   operand,
    output logic [15:0]  pc,
    output logic         sync,
    output logic         opcode_valid,
    output logic [1:0]   int_src,
    output fetch_state_t state
);

    fetch_state_t state_next;
    logic [15:0]  pc_next;
    logic [7:0]   opcode_next;
    logic [7:0]   operand_next;
    logic [1:0]   int_src_next;
    logic         int_pending;
    logic [1:0]   int_sel;
    logic         capture;

    assign capture = (state == S_OPCODE) && rdy && int_pending;

    int_ctl u_int_ctl (
        .clk     (i_clk),
        .rst     (i_rst),
        .nmi_n   (nmi_n),
        .irq_n   (irq_n),
        .i_flag  (i_flag),
        .capture (capture),
        .pending (int_pending),
        .src     (int_sel)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_OPCODE;
            pc      <= PC_INIT;
            opcode  <= 8'h00;
            operand <= 8'h00;
            int_src <= INT_NONE;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            opcode  <= opcode_next;
            operand <= operand_next;
            int_src <= int_src_next;
        end
    end

    always_comb begin
        state_next   = state;
        pc_next      = pc;
        opcode_next  = opcode;
        operand_next = operand;
        int_src_next = int_src;
        unique case (state)
            S_OPCODE: begin
                if (rdy) begin
                    state_next = S_OPERAND;
                    if (int_pending) begin
                        opcode_next  = OP_BRK;
                        int_src_next = int_sel;
                    end else begin
                        opcode_next  = data_i;
                        int_src_next = INT_NONE;
                        pc_next      = pc + 16'd1;
                    end
                end
            end
            S_OPERAND: begin
                if (rdy) begin
                    state_next   = S_EXEC;
                    operand_next = data_i;
                    // Forced BRK re-reads the same byte without consuming it.
                    if (!single_byte && int_src == INT_NONE) begin
                        pc_next = pc + 16'd1;
                    end
                end
            end
            S_EXEC: begin
                if (pc_load) begin
                    pc_next = pc_in;
                end else if (pc_inc) begin
                    pc_next = pc + 16'd1;
                end
                if (fetch_req) begin
                    state_next = S_OPCODE;
                end
            end
            default: begin
                state_next = S_OPCODE;
            end
        endcase
    end

    assign addr_o       = pc;
    assign sync         = (state == S_OPCODE);
    assign opcode_valid = (state == S_EXEC);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: each task walks one scenario cycle by cycle
// and compares outputs against hand-computed values.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic         i_clk;
    logic         i_rst;
    logic         rdy;
    logic [7:0]   data_i;
    logic [15:0]  addr_o;
    logic         fetch_req;
    logic         single_byte;
    logic         pc_inc;
    logic         pc_load;
    logic [15:0]  pc_in;
    logic         nmi_n;
    logic         irq_n;
    logic         i_flag;
    logic [7:0]   opcode;
    logic [7:0]   operand;
    logic [15:0]  pc;
    logic         sync;
    logic         opcode_valid;
    logic [1:0]   int_src;
    fetch_state_t state;

    logic [7:0] mem [0:65535];
    int pass_cnt = 0;
    int total_cnt = 0;

    fetch_unit #(.PC_INIT(16'h0000)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .rdy          (rdy),
        .data_i       (data_i),
        .addr_o       (addr_o),
        .fetch_req    (fetch_req),
        .single_byte  (single_byte),
        .pc_inc       (pc_inc),
        .pc_load      (pc_load),
        .pc_in        (pc_in),
        .nmi_n        (nmi_n),
        .irq_n        (irq_n),
        .i_flag       (i_flag),
        .opcode       (opcode),
        .operand      (operand),
        .pc           (pc),
        .sync         (sync),
        .opcode_valid (opcode_valid),
        .int_src      (int_src),
        .state        (state)
    );

    // Clock and memory model
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    assign data_i = mem[addr_o];

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic jump_and_fetch(input logic [15:0] a);
        pc_load   = 1'b1;
        pc_in     = a;
        fetch_req = 1'b1;
        tick();
        pc_load   = 1'b0;
        fetch_req = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        tick();
        total_cnt++; if (opcode !== 8'h00) $display("FAIL reset_opcode: got %h want 00", opcode); else pass_cnt++;
        total_cnt++; if (operand !== 8'h00) $display("FAIL reset_operand: got %h want 00", operand); else pass_cnt++;
        total_cnt++; if (pc !== 16'h0000) $display("FAIL reset_pc: got %h want 0000", pc); else pass_cnt++;
        total_cnt++; if (int_src !== 2'd0) $display("FAIL reset_int_src: got %0d want 0", int_src); else pass_cnt++;
        total_cnt++; if (opcode_valid !== 1'b0 || sync !== 1'b1) $display("FAIL reset_flags: got valid=%b sync=%b want 0/1", opcode_valid, sync); else pass_cnt++;
        i_rst = 1'b0;
        tick();
        total_cnt++; if (opcode !== 8'h00 || int_src !== 2'd3 || pc !== 16'h0000) $display("FAIL reset_brk: got op=%h src=%0d pc=%h want 00/3/0000", opcode, int_src, pc); else pass_cnt++;
        tick();
        total_cnt++; if (state !== S_EXEC || opcode_valid !== 1'b1 || pc !== 16'h0000) $display("FAIL reset_brk_exec: got st=%0d valid=%b pc=%h want 2/1/0000", state, opcode_valid, pc); else pass_cnt++;
        jump_and_fetch(16'h8000);
        total_cnt++; if (addr_o !== 16'h8000 || sync !== 1'b1) $display("FAIL vector_addr: got %h sync=%b want 8000/1", addr_o, sync); else pass_cnt++;
        tick();
        total_cnt++; if (opcode !== 8'hA9 || int_src !== 2'd0 || pc !== 16'h8001) $display("FAIL vector_opcode: got op=%h src=%0d pc=%h want A9/0/8001", opcode, int_src, pc); else pass_cnt++;
        tick();
        total_cnt++; if (operand !== 8'h55 || pc !== 16'h8002 || state !== S_EXEC) $display("FAIL vector_operand: got %h pc=%h st=%0d want 55/8002/2", operand, pc, state); else pass_cnt++;
    endtask

    task automatic test_single_byte();
        jump_and_fetch(16'h1000);
        single_byte = 1'b1;
        tick();
        tick();
        single_byte = 1'b0;
        total_cnt++; if (opcode !== 8'hE8 || operand !== 8'h77 || pc !== 16'h1001) $display("FAIL single_byte: got op=%h opr=%h pc=%h want E8/77/1001", opcode, operand, pc); else pass_cnt++;
    endtask

    task automatic test_stall();
        jump_and_fetch(16'h2000);
        rdy = 1'b0;
        tick();
        total_cnt++; if (state !== S_OPCODE || sync !== 1'b1 || pc !== 16'h2000 || opcode !== 8'hE8) $display("FAIL stall_opcode: got st=%0d sync=%b pc=%h op=%h want 0/1/2000/E8", state, sync, pc, opcode); else pass_cnt++;
        rdy = 1'b1;
        tick();
        total_cnt++; if (opcode !== 8'hAD || pc !== 16'h2001) $display("FAIL stall_pre: got op=%h pc=%h want AD/2001", opcode, pc); else pass_cnt++;
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++; if (operand !== 8'h77 || pc !== 16'h2001 || state !== S_OPERAND) $display("FAIL stall_operand%0d: got opr=%h pc=%h st=%0d want 77/2001/1", i, operand, pc, state); else pass_cnt++;
        end
        rdy = 1'b1;
        tick();
        total_cnt++; if (operand !== 8'h34 || pc !== 16'h2002 || state !== S_EXEC) $display("FAIL stall_release: got opr=%h pc=%h st=%0d want 34/2002/2", operand, pc, state); else pass_cnt++;
    endtask

    task automatic test_irq();
        irq_n  = 1'b0;
        i_flag = 1'b1;
        jump_and_fetch(16'h3000);
        tick();
        total_cnt++; if (opcode !== 8'hEA || int_src !== 2'd0 || pc !== 16'h3001) $display("FAIL irq_masked: got op=%h src=%0d pc=%h want EA/0/3001", opcode, int_src, pc); else pass_cnt++;
        tick();
        i_flag    = 1'b0;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        total_cnt++; if (opcode !== 8'h00 || int_src !== 2'd1 || pc !== 16'h3002) $display("FAIL irq_brk: got op=%h src=%0d pc=%h want 00/1/3002", opcode, int_src, pc); else pass_cnt++;
        tick();
        total_cnt++; if (operand !== 8'h22 || pc !== 16'h3002) $display("FAIL irq_brk_operand: got opr=%h pc=%h want 22/3002", operand, pc); else pass_cnt++;
    endtask

    task automatic test_nmi();
        nmi_n = 1'b0;
        tick();
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        total_cnt++; if (opcode !== 8'h00 || int_src !== 2'd2 || pc !== 16'h3002) $display("FAIL nmi_over_irq: got op=%h src=%0d pc=%h want 00/2/3002", opcode, int_src, pc); else pass_cnt++;
        tick();
        irq_n     = 1'b1;
        i_flag    = 1'b1;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        total_cnt++; if (opcode !== 8'h22 || int_src !== 2'd0 || pc !== 16'h3003) $display("FAIL nmi_cleared: got op=%h src=%0d pc=%h want 22/0/3003", opcode, int_src, pc); else pass_cnt++;
        tick();
        nmi_n = 1'b1;
        tick();
        nmi_n = 1'b0;
        tick();
        nmi_n = 1'b1;
        tick();
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        nmi_n = 1'b0;
        tick();
        total_cnt++; if (opcode !== 8'h00 || int_src !== 2'd2) $display("FAIL nmi_first: got op=%h src=%0d want 00/2", opcode, int_src); else pass_cnt++;
        tick();
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        total_cnt++; if (opcode !== 8'h00 || int_src !== 2'd2 || pc !== 16'h3004) $display("FAIL nmi_relatch: got op=%h src=%0d pc=%h want 00/2/3004", opcode, int_src, pc); else pass_cnt++;
        tick();
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        total_cnt++; if (opcode !== 8'hEA || int_src !== 2'd0 || pc !== 16'h3005) $display("FAIL nmi_done: got op=%h src=%0d pc=%h want EA/0/3005", opcode, int_src, pc); else pass_cnt++;
        tick();
        nmi_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        jump_and_fetch(16'hC000);
        total_cnt++; if (addr_o !== 16'hC000 || state !== S_OPCODE) $display("FAIL load_fetch_addr: got %h st=%0d want C000/0", addr_o, state); else pass_cnt++;
        tick();
        tick();
        pc_inc  = 1'b1;
        pc_load = 1'b1;
        pc_in   = 16'h4000;
        tick();
        pc_load = 1'b0;
        total_cnt++; if (pc !== 16'h4000 || state !== S_EXEC) $display("FAIL load_beats_inc: got pc=%h st=%0d want 4000/2", pc, state); else pass_cnt++;
        tick();
        pc_inc = 1'b0;
        total_cnt++; if (pc !== 16'h4001) $display("FAIL pc_inc: got %h want 4001", pc); else pass_cnt++;
        fetch_req = 1'b1;
        tick();
        pc_inc  = 1'b1;
        pc_load = 1'b1;
        pc_in   = 16'h1234;
        tick();
        total_cnt++; if (opcode !== 8'hC8 || pc !== 16'h4002 || state !== S_OPERAND) $display("FAIL ignore_outside_exec: got op=%h pc=%h st=%0d want C8/4002/1", opcode, pc, state); else pass_cnt++;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        fetch_req = 1'b0;
        tick();
        total_cnt++; if (pc !== 16'h4003 || state !== S_EXEC) $display("FAIL ignore_exec_after: got pc=%h st=%0d want 4003/2", pc, state); else pass_cnt++;
    endtask

    task automatic test_wrap();
        jump_and_fetch(16'hFFFF);
        tick();
        total_cnt++; if (opcode !== 8'hA5 || pc !== 16'h0000) $display("FAIL wrap_opcode: got op=%h pc=%h want A5/0000", opcode, pc); else pass_cnt++;
        tick();
        total_cnt++; if (operand !== 8'hA9 || pc !== 16'h0001) $display("FAIL wrap_operand: got opr=%h pc=%h want A9/0001", operand, pc); else pass_cnt++;
    endtask

    task automatic test_reset_mid_stall();
        jump_and_fetch(16'h5000);
        tick();
        rdy = 1'b0;
        tick();
        total_cnt++; if (state !== S_OPERAND || pc !== 16'h5001 || opcode !== 8'hAD) $display("FAIL mid_stall: got st=%0d pc=%h op=%h want 1/5001/AD", state, pc, opcode); else pass_cnt++;
        i_rst = 1'b1;
        tick();
        total_cnt++; if (state !== S_OPCODE || pc !== 16'h0000 || opcode !== 8'h00 || operand !== 8'h00 || int_src !== 2'd0 || sync !== 1'b1 || opcode_valid !== 1'b0) $display("FAIL mid_reset: got st=%0d pc=%h op=%h opr=%h src=%0d sync=%b valid=%b want 0/0000/00/00/0/1/0", state, pc, opcode, operand, int_src, sync, opcode_valid); else pass_cnt++;
        i_rst = 1'b0;
        rdy   = 1'b1;
        tick();
        total_cnt++; if (opcode !== 8'h00 || int_src !== 2'd3 || pc !== 16'h0000) $display("FAIL mid_reset_brk: got op=%h src=%0d pc=%h want 00/3/0000", opcode, int_src, pc); else pass_cnt++;
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[16'h0000] = 8'hA9;
        mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h55;
        mem[16'h1000] = 8'hE8; mem[16'h1001] = 8'h77;
        mem[16'h2000] = 8'hAD; mem[16'h2001] = 8'h34;
        mem[16'h3000] = 8'hEA; mem[16'h3001] = 8'h11;
        mem[16'h3002] = 8'h22; mem[16'h3004] = 8'hEA;
        mem[16'hC000] = 8'hEA; mem[16'hC001] = 8'h01;
        mem[16'h4001] = 8'hC8; mem[16'hFFFF] = 8'hA5;
        mem[16'h5000] = 8'hAD;
        i_rst = 1'b1; rdy = 1'b1; fetch_req = 1'b0; single_byte = 1'b0;
        pc_inc = 1'b0; pc_load = 1'b0; pc_in = 16'h0000;
        nmi_n = 1'b1; irq_n = 1'b1; i_flag = 1'b1;
        test_reset();
        test_single_byte();
        test_stall();
        test_irq();
        test_nmi();
        test_back_to_back();
        test_wrap();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage sitting directly upstream of the opcode decoder. It owns the program counter and drives the bus address during opcode and operand fetch cycles. It latches the opcode into the instruction register, which feeds the decoder, and latches the first operand byte. It injects a forced BRK opcode (8'h00) for reset, NMI and IRQ, and holds the fetched instruction until the execution sequencer requests the next fetch.

Parameters:
PC_INIT, 16'h0000, PC value loaded on reset. The forced reset-BRK sequence then loads the vector through pc_load.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset; one clock, reset synchronous and active-high
rdy  in  1  bus ready; low stalls fetch cycles
data_i  in  8  memory read data, sampled at the rising edge ending the cycle in which addr_o is driven
addr_o  out  16  fetch address; equals pc in S_OPCODE/S_OPERAND, else don't-care
fetch_req  in  1  sequencer reached T0_FETCH; start next instruction
single_byte  in  1  from decoder, combinational on opcode; suppresses operand PC increment
pc_inc  in  1  sequencer consumed an extra instruction byte; pc+1
pc_load  in  1  load pc from pc_in (jump/branch/vector)
pc_in  in  16  new PC value
nmi_n  in  1  non-maskable interrupt, falling-edge sensitive
irq_n  in  1  interrupt request, level, active-low
i_flag  in  1  processor status I bit
opcode  out  8  instruction register, feeds decoder
operand  out  8  byte following the opcode
pc  out  16  current program counter
sync  out  1  high during the opcode fetch cycle
opcode_valid  out  1  high in S_EXEC; opcode/operand stable
int_src  out  2  cause of the current forced BRK: 0 none, 1 IRQ, 2 NMI, 3 RESET

Behaviour:
- FSM states: S_OPCODE, S_OPERAND, S_EXEC. The reset state is S_OPCODE.
- Reset values: opcode 8'h00, operand 8'h00, pc PC_INIT, int_src 0, opcode_valid 0, sync 1.
- Reset also sets reset_pending=1 and clears the nmi latch and the nmi_n edge register (set to 1).
- S_OPCODE:
  - sync=1, addr_o=pc.
  - If rdy=1 and an interrupt is pending: opcode<=8'h00, int_src<=highest-priority source, pc unchanged.
  - If rdy=1 and nothing is pending: opcode<=data_i, int_src<=0, pc<=pc+1.
  - Next state: S_OPERAND.
- S_OPERAND:
  - addr_o=pc.
  - If rdy=1: operand<=data_i, then next state S_EXEC.
  - pc<=pc+1 only if !single_byte and int_src==0.
- S_EXEC:
  - opcode_valid=1; opcode and operand are held.
  - pc_load loads pc_in. pc_inc increments pc. pc_load wins if both are asserted.
  - fetch_req moves to S_OPCODE next cycle. A pc_load in the same cycle takes effect first, so the next fetch uses pc_in.
- rdy=0 in S_OPCODE/S_OPERAND: state, pc, opcode and operand are all held. sync stays asserted.
- fetch_req, pc_inc and pc_load are ignored outside S_EXEC.
- Interrupt priority: RESET > NMI > IRQ.
  - NMI: latched on a 1->0 transition of registered nmi_n.
  - IRQ pending = !irq_n && !i_flag, sampled in S_OPCODE.
- The forced-BRK source flag (reset_pending or nmi latch) clears at the edge where the forced opcode is captured.
  - An NMI edge arriving in that same cycle is re-latched, not lost.
- PC arithmetic is 16-bit and wraps 16'hFFFF -> 16'h0000.
- i_rst asserted in any state, including mid-stall, returns all registers to their reset values on the next edge.

Decomposition:
- Shared package (alongside the existing defs): fetch state enum, INT_NONE/INT_IRQ/INT_NMI/INT_RESET codes, OP_BRK=8'h00 constant.
- One natural sub-module, int_ctl: nmi edge detector, pending latches, priority encoder.
- PC register and FSM stay in fetch_unit.

Test Plan:
- Reset release, data_i=8'hA9: first capture gives opcode=8'h00, int_src=3, pc=PC_INIT.
  - Next fetch after pc_load 16'h8000 reads A9 at 8000 and operand at 8001; pc=8002.
- Single-byte fetch at pc=16'h1000, data 8'hE8 (INX) with single_byte=1: opcode=E8, operand=next byte, pc=1001 in S_EXEC.
- rdy low 3 cycles in S_OPERAND: operand unchanged and pc unchanged across the stall; capture on the first rdy=1 edge.
- irq_n=0 with i_flag=1: normal fetch. With i_flag=0: opcode=00, int_src=1, pc not incremented.
  - NMI edge plus IRQ together gives int_src=2.
- fetch_req and pc_load (pc_in=16'hC000) in the same S_EXEC cycle: next addr_o=C000.
  - pc_inc and pc_load together: pc=pc_in.
- pc=16'hFFFF two-byte fetch: pc wraps to 16'h0001. i_rst mid-S_OPERAND: reset values restored next cycle.
